ram_write_arbiter: RTL

Arbitrates stereo I2S capture samples into the single write port of the ping-pong RAM buffer. Each capture pulse carries one left and one right 24-bit sample. Enabled channels are queued in per-channel FIFOs and drained round-robin through a valid/ready write port as tagged 32-bit words. Queue overflow is counted and flagged rather than stalling capture. The block sits between the I2S capture module and the RAM buffer logic.

---
 rtl/ram_write_arbiter_pkg.sv | 13 +
 rtl/arb_chan_fifo.sv | 52 +++++
 rtl/ram_write_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ram_write_arbiter_pkg.sv
// Shared types and constants for the I2S capture to RAM write arbiter.
package ram_write_arbiter_pkg;

    typedef enum logic {CH_LEFT, CH_RIGHT} ch_e;
    typedef logic signed [23:0] sample_t;

    localparam logic [7:0]  TAG_LEFT   = 8'h00;
    localparam logic [7:0]  TAG_RIGHT  = 8'h01;
    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TAG_W      = 8;

endpackage

// File: rtl/arb_chan_fifo.sv
// Per-channel synchronous FIFO; a push into a full FIFO succeeds only if it is popped in the same cycle.
module arb_chan_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 24
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_c_o,
    output logic         full_c_o,
    output logic         empty_c_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty.
    assign empty_c_o = (wr_ptr_q == rd_ptr_q);
    assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_c_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop_i && !empty_c_o;
        do_push  = push_i && (!full_c_o || do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Queues stereo capture samples per channel and drains them round-robin as tagged
// 32-bit words through a valid/ready RAM write port, counting overflow drops.
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          CH_TAG_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            enable_i,
    input  logic [SAMPLE_W-1:0]   left_i,
    input  logic [SAMPLE_W-1:0]   right_i,
    input  logic                  sample_valid_i,
    output logic [WORD_W-1:0]     write_data_o,
    output logic                  write_valid_o,
    input  logic                  write_ready_i,
    input  logic                  clear_i,
    output logic [DROP_CNT_W-1:0] drop_count_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    sample_t                 l_sample, r_sample;
    logic                    l_full, l_empty, r_full, r_empty;
    logic                    push_l, push_r, pop_l, pop_r;
    logic                    drop_l, drop_r, load;
    ch_e                     grant;
    ch_e                     last_q, last_d;
    logic                    valid_q, valid_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic [DROP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [DROP_CNT_W:0]     cnt_sum;
    logic [TAG_W-1:0]        tag_r;

    arb_chan_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo_l (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push_l),
        .data_i    (left_i),
        .pop_i     (pop_l),
        .data_c_o  (l_sample),
        .full_c_o  (l_full),
        .empty_c_o (l_empty)
    );

    arb_chan_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo_r (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push_r),
        .data_i    (right_i),
        .pop_i     (pop_r),
        .data_c_o  (r_sample),
        .full_c_o  (r_full),
        .empty_c_o (r_empty)
    );

    // Arbitration, output register reload and drop accounting.
    always_comb begin
        push_l  = sample_valid_i && enable_i[0];
        push_r  = sample_valid_i && enable_i[1];
        pop_l   = 1'b0;
        pop_r   = 1'b0;
        last_d  = last_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tag_r   = CH_TAG_EN ? TAG_RIGHT : TAG_LEFT;

        if (!l_empty && !r_empty) begin
            grant = (last_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
        end else begin
            grant = !l_empty ? CH_LEFT : CH_RIGHT;
        end

        load = !valid_q || write_ready_i;
        if (load) begin
            valid_d = !l_empty || !r_empty;
            if (!l_empty || !r_empty) begin
                last_d = grant;
                if (grant == CH_LEFT) begin
                    pop_l  = 1'b1;
                    data_d = {TAG_LEFT, (WORD_W-TAG_W)'(l_sample)};
                end else begin
                    pop_r  = 1'b1;
                    data_d = {tag_r, (WORD_W-TAG_W)'(r_sample)};
                end
            end
        end

        drop_l  = push_l && l_full && !pop_l;
        drop_r  = push_r && r_full && !pop_r;
        cnt_sum = {1'b0, cnt_q} + (DROP_CNT_W+1)'(drop_l) + (DROP_CNT_W+1)'(drop_r);

        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            cnt_d = cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
            if (drop_l || drop_r) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= CH_RIGHT;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign write_data_o  = data_q;
    assign write_valid_o = valid_q;
    assign drop_count_o  = cnt_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = !l_empty || !r_empty || valid_q;

endmodule
